// File: rtl/storage_pkg.sv
// Shared framing constants and the one-hot transmitter state encoding
// used by the storage-side UART transmitter.
package storage_pkg;

   localparam logic [7:0] FRAME_MARK = 8'h80;
   localparam logic [7:0] FRAME_HDR  = 8'h02;
   localparam logic [7:0] FRAME_TRL  = 8'h01;

   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      START = 4'b0010,
      DATA  = 4'b0100,
      STOP  = 4'b1000
   } tx_state_e;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serializer: baud counter, shift register and START/DATA/STOP sequencing.
// A byte is accepted on load while ready; the line idles high.
module uart_tx_core
   import storage_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] data,
   output logic       ready,
   output logic       tx,
   output logic       busy
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   tx_state_e         state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_d;
   logic              baud_done;

   assign baud_done = (baud_q == BAUD_LAST);
   assign ready     = (state_q == IDLE);
   assign busy      = !ready;

   // NOTE: every signal gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      unique case (state_q)
         IDLE: begin
            baud_d = '0;
            if (load) begin
               state_d = START;
               shift_d = data;
               bit_d   = '0;
            end
         end
         START: begin
            if (baud_done) begin
               state_d = DATA;
               baud_d  = '0;
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (baud_done) begin
               state_d = IDLE;
               baud_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      // The line level is registered from the next state so TxOut is glitch-free.
      tx_d = 1'b1;
      if (state_d == START)     tx_d = 1'b0;
      else if (state_d == DATA) tx_d = shift_d[0];
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx      <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx      <= tx_d;
      end
   end

endmodule

// File: rtl/storage_uart_tx.sv
// Storage-side UART transmitter: pulls bytes from the accumulator storage block,
// sends them as 8N1 and reports the byte length of each framed packet.
module storage_uart_tx
   import storage_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int CNT_W        = 16
) (
   input  logic             ReadClock,
   input  logic             Reset,
   input  logic             Enable,
   input  logic [7:0]       DataIn,
   input  logic             DataReady,
   output logic             ReadEnable,
   output logic             TxOut,
   output logic             Busy,
   output logic             FrameStart,
   output logic             FrameDone,
   output logic [CNT_W-1:0] FrameLength
);

   logic             ready;
   logic             capture;
   logic             prev80;
   logic [CNT_W-1:0] byte_cnt;
   logic [CNT_W-1:0] cnt_next;

   assign capture  = ready && Enable && DataReady;
   assign cnt_next = (&byte_cnt) ? byte_cnt : byte_cnt + 1'b1;

   uart_tx_core #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_core (
      .clk  (ReadClock),
      .rst  (Reset),
      .load (capture),
      .data (DataIn),
      .ready(ready),
      .tx   (TxOut),
      .busy (Busy)
   );

   // The monitor only sees byte pairs, so 0x80,0x01 inside a payload ends the frame early.
   always_ff @(posedge ReadClock) begin
      if (Reset) begin
         ReadEnable  <= 1'b0;
         FrameStart  <= 1'b0;
         FrameDone   <= 1'b0;
         FrameLength <= '0;
         byte_cnt    <= '0;
         prev80      <= 1'b0;
      end else begin
         ReadEnable <= capture;
         FrameStart <= 1'b0;
         FrameDone  <= 1'b0;
         if (capture) begin
            prev80 <= (DataIn == FRAME_MARK);
            if (prev80 && DataIn == FRAME_HDR) begin
               byte_cnt   <= CNT_W'(2);
               FrameStart <= 1'b1;
            end else if (prev80 && DataIn == FRAME_TRL) begin
               FrameLength <= cnt_next;
               byte_cnt    <= '0;
               FrameDone   <= 1'b1;
            end else begin
               byte_cnt <= cnt_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_storage_uart_tx.sv
// Self-checking bench for storage_uart_tx: a vector table, directed corner
// sequences and a randomized byte stream checked against a frame model.
module tb_storage_uart_tx;

   localparam int CPB   = 4;
   localparam int CNT_W = 16;

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;   // line bits {stop, d7..d0, start}
   } vec_t;

   logic             clk = 1'b0;
   logic             Reset = 1'b1;
   logic             Enable = 1'b0;
   logic [7:0]       DataIn = 8'h00;
   logic             DataReady = 1'b0;
   logic             ReadEnable, TxOut, Busy, FrameStart, FrameDone;
   logic [CNT_W-1:0] FrameLength;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] up_q[$];
   logic       up_gate = 1'b1;
   logic [9:0] rx_frames[$];
   logic [9:0] dec_frame;
   logic [7:0] sent[$];
   int         re_total = 0;
   int         re_base = 0;
   int         fs_pos[$], fd_pos[$], fd_len[$];
   int         exp_fs_pos[$], exp_fd_pos[$], exp_fd_len[$];

   always #5 clk = ~clk;

   storage_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .CNT_W       (CNT_W)
   ) dut (
      .ReadClock  (clk),
      .Reset      (Reset),
      .Enable     (Enable),
      .DataIn     (DataIn),
      .DataReady  (DataReady),
      .ReadEnable (ReadEnable),
      .TxOut      (TxOut),
      .Busy       (Busy),
      .FrameStart (FrameStart),
      .FrameDone  (FrameDone),
      .FrameLength(FrameLength)
   );

   // Upstream storage model: a byte is consumed when ReadEnable is seen.
   always begin
      @(negedge clk);
      #1;
      if (ReadEnable === 1'b1 && up_q.size() != 0) void'(up_q.pop_front());
      DataIn    = (up_q.size() != 0) ? up_q[0] : 8'h00;
      DataReady = up_gate && (up_q.size() != 0);
   end

   // Serial decoder: samples each bit near its middle.
   always begin
      @(negedge clk);
      if (TxOut === 1'b0) begin
         for (int j = 0; j < 10; j++) begin
            repeat ((j == 0) ? 1 : CPB) @(negedge clk);
            dec_frame[j] = TxOut;
         end
         rx_frames.push_back(dec_frame);
      end
   end

   // Event log, positions expressed as the ReadEnable count at the event.
   always begin
      @(negedge clk);
      if (ReadEnable === 1'b1) re_total = re_total + 1;
      if (FrameStart === 1'b1) fs_pos.push_back(re_total);
      if (FrameDone === 1'b1) begin
         fd_len.push_back(int'(FrameLength));
         fd_pos.push_back(re_total);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      repeat (3) @(negedge clk);
      Reset = 1'b0;
      fs_pos.delete();
      fd_pos.delete();
      fd_len.delete();
      rx_frames.delete();
      re_base = re_total;
   endtask

   task automatic wait_drain(input int budget, input string name);
      int n;
      logic done;
      n = 0;
      done = 1'b0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
         if (up_q.size() == 0 && Busy === 1'b0) done = 1'b1;
      end
      check(name, done, 1);
   endtask

   // Higher-level frame model: a frame begins at the 0x80 of a header, or right
   // after the previous trailer, or at the start of the stream.
   task automatic run_model();
      int frm_begin;
      frm_begin = 0;
      exp_fs_pos.delete();
      exp_fd_pos.delete();
      exp_fd_len.delete();
      for (int i = 1; i < sent.size(); i++) begin
         if (sent[i-1] == 8'h80 && sent[i] == 8'h02) begin
            frm_begin = i - 1;
            exp_fs_pos.push_back(i + 1);
         end else if (sent[i-1] == 8'h80 && sent[i] == 8'h01) begin
            exp_fd_len.push_back(i - frm_begin + 1);
            exp_fd_pos.push_back(i + 1);
            frm_begin = i + 1;
         end
      end
   endtask

   task automatic compare_stream(input string name);
      int bad;
      bad = 0;
      for (int k = 0; k < sent.size(); k++)
         if (k >= rx_frames.size() || rx_frames[k] !== {1'b1, sent[k], 1'b0}) bad++;
      check({name, "_rx_count"}, rx_frames.size(), sent.size());
      check({name, "_rx_bad"}, bad, 0);
      check({name, "_re_pulses"}, re_total - re_base, sent.size());
      check({name, "_fs_count"}, fs_pos.size(), exp_fs_pos.size());
      for (int k = 0; k < exp_fs_pos.size() && k < fs_pos.size(); k++)
         check($sformatf("%s_fs_pos%0d", name, k), fs_pos[k] - re_base, exp_fs_pos[k]);
      check({name, "_fd_count"}, fd_len.size(), exp_fd_len.size());
      for (int k = 0; k < exp_fd_len.size() && k < fd_len.size(); k++) begin
         check($sformatf("%s_fd_len%0d", name, k), fd_len[k], exp_fd_len[k]);
         check($sformatf("%s_fd_pos%0d", name, k), fd_pos[k] - re_base, exp_fd_pos[k]);
      end
   endtask

   initial begin
      vec_t       vecs[5];
      int         re0, errs, busy_hi, r;
      logic [7:0] b;
      logic       done;

      vecs[0] = '{8'h55, 10'b1_01010101_0};
      vecs[1] = '{8'h00, 10'b1_00000000_0};
      vecs[2] = '{8'hFF, 10'b1_11111111_0};
      vecs[3] = '{8'h80, 10'b1_10000000_0};
      vecs[4] = '{8'h3C, 10'b1_00111100_0};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_tx", TxOut, 1);
      check("rst_read_enable", ReadEnable, 0);
      check("rst_busy", Busy, 0);
      check("rst_frame_start", FrameStart, 0);
      check("rst_frame_done", FrameDone, 0);
      check("rst_frame_length", FrameLength, 0);
      Reset = 1'b0;
      Enable = 1'b1;
      @(negedge clk);

      // Exact line waveform for 0x55
      re0 = re_total;
      errs = 0;
      busy_hi = 0;
      up_q.push_back(8'h55);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (TxOut !== vecs[0].frame[k / CPB]) errs++;
         if (Busy === 1'b1) busy_hi++;
      end
      @(negedge clk);
      check("wave_tx_errs", errs, 0);
      check("wave_busy_cycles", busy_hi, 40);
      check("wave_busy_end", Busy, 0);
      check("wave_tx_idle_after", TxOut, 1);
      check("wave_re_pulses", re_total - re0, 1);

      // Vector table
      for (int i = 0; i < 5; i++) begin
         rx_frames.delete();
         up_q.push_back(vecs[i].data);
         wait_drain(200, $sformatf("vec%0d_drain", i));
         check($sformatf("vec%0d_frame", i), (rx_frames.size() != 0) ? rx_frames[0] : 10'h000,
               vecs[i].frame);
      end

      // Enable dropped mid-byte: byte completes, next waits for Enable
      rx_frames.delete();
      re0 = re_total;
      up_q.push_back(8'hA3);
      up_q.push_back(8'h5C);
      repeat (10) @(negedge clk);
      Enable = 1'b0;
      repeat (100) @(negedge clk);
      check("en_low_re_pulses", re_total - re0, 1);
      check("en_low_frame_a3", (rx_frames.size() != 0) ? rx_frames[0] : 10'h000, 10'b1_10100011_0);
      check("en_low_busy", Busy, 0);
      Enable = 1'b1;
      @(negedge clk);
      check("en_return_capture", ReadEnable, 1);
      wait_drain(200, "en_drain");
      check("en_frame_5c", (rx_frames.size() > 1) ? rx_frames[1] : 10'h000, 10'b1_01011100_0);

      // Reset during DATA bit 4 of 0x0F
      re0 = re_total;
      up_q.push_back(8'h0F);
      up_q.push_back(8'h66);
      repeat (22) @(negedge clk);
      check("mid_bit4_tx", TxOut, 0);
      Reset = 1'b1;
      @(negedge clk);
      check("mid_rst_tx", TxOut, 1);
      check("mid_rst_busy", Busy, 0);
      repeat (40) @(negedge clk);
      check("mid_rst_no_capture", re_total - re0, 1);
      rx_frames.delete();
      Reset = 1'b0;
      @(negedge clk);
      check("mid_rst_fresh_capture", ReadEnable, 1);
      wait_drain(200, "mid_rst_drain");
      check("mid_rst_frame_66", (rx_frames.size() != 0) ? rx_frames[0] : 10'h000, 10'b1_01100110_0);

      // DataReady low for 1000 cycles
      re0 = re_total;
      errs = 0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (TxOut !== 1'b1 || Busy !== 1'b0 || DataReady !== 1'b0) errs++;
      end
      check("idle_line_errs", errs, 0);
      check("idle_re_pulses", re_total - re0, 0);

      // Embedded trailer inside payload ends the frame early
      do_reset();
      sent = {8'h80, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
              8'h80, 8'h01, 8'h66, 8'h77, 8'h88, 8'h80, 8'h01};
      exp_fs_pos = {2};
      exp_fd_len = {9, 5};
      exp_fd_pos = {9, 14};
      foreach (sent[k]) up_q.push_back(sent[k]);
      wait_drain(1000, "early_drain");
      compare_stream("early");

      // Full frame: header, 1024 payload bytes, trailer
      do_reset();
      sent = {8'h80, 8'h02};
      for (int k = 0; k < 1024; k++) begin
         b = 8'($urandom_range(0, 255));
         if (b == 8'h80) b = 8'h7F;
         sent.push_back(b);
      end
      sent.push_back(8'h80);
      sent.push_back(8'h01);
      exp_fs_pos = {2};
      exp_fd_len = {1028};
      exp_fd_pos = {1028};
      foreach (sent[k]) up_q.push_back(sent[k]);
      wait_drain(44000, "frame_drain");
      compare_stream("frame");
      check("frame_length_held", FrameLength, 1028);

      // Randomized stream with Enable/DataReady gating, checked against the model
      do_reset();
      sent.delete();
      for (int k = 0; k < 120; k++) begin
         r = int'($urandom_range(0, 9));
         case (r)
            0, 1, 2: b = 8'h80;
            3:       b = 8'h01;
            4:       b = 8'h02;
            default: b = 8'($urandom_range(0, 255));
         endcase
         sent.push_back(b);
      end
      run_model();
      foreach (sent[k]) up_q.push_back(sent[k]);
      done = 1'b0;
      for (int c = 0; c < 12000 && !done; c++) begin
         @(negedge clk);
         Enable  = ($urandom_range(0, 4) != 0);
         up_gate = ($urandom_range(0, 4) != 0);
         if (up_q.size() == 0 && Busy === 1'b0) done = 1'b1;
      end
      Enable  = 1'b1;
      up_gate = 1'b1;
      check("rand_drain", done, 1);
      compare_stream("rand");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
